split_view_compositor: RTL and testbench

- Pipelined, parametrised successor to the two-player split-screen renderer.
- Takes VGA scan counters and NUM_VIEWS player world positions, divides the active area into NUM_VIEWS equal vertical strips, and generates one camera-relative map BRAM address per pixel.
- Composites map colour (through a writable 16-entry palette), external sprite colour, separators and the HUD band; emits RGB with sync signals delay-matched.
- Sits between vga_controller / PhysicsEngine and the VGA pins.

---
 rtl/split_view_compositor.sv | 261 ++++++++++++++++++++++++++
 tb/tb_split_view_compositor.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/split_view_compositor.sv
// split_view_compositor
//   Splits the active area into NUM_VIEWS equal vertical strips. Each strip gets
//   its own camera, which follows one player and is latched once per frame. The
//   block generates a map BRAM address for every pixel, then composites the map
//   colour (looked up in a writable 16-entry palette), the sprite colour, the
//   separators and the HUD band. Syncs pass through the same 3-stage pipeline,
//   so they stay aligned with the colour.
//   Optional feature: define CAMERA_CLAMP_EN to clamp each camera into the map
//   at latch time.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   pix_en                    pixel strobe; the pipeline advances only on it
//   h_cnt, v_cnt, valid_in,
//   hsync_in, vsync_in        scan timing from the VGA controller
//   pos_x, pos_y              packed player world positions, 10 bits per view
//   map_addr / map_index      map BRAM address out (stage 1), data in (stage 2)
//   sprite_rgb, sprite_opaque external sprite, sampled in stage 2
//   pal_we, pal_idx, pal_data palette write port (not gated by pix_en)
//   view_id, view_x           stage-1 viewport index and x within the viewport
//   frame_start               one-clk pulse when the cameras latch
//   rgb, hsync, vsync         composited output, 3 strobes after the inputs
module split_view_compositor #(
    parameter int unsigned NUM_VIEWS  = 2,
    parameter int unsigned ZOOM_SHIFT = 2,
    parameter int unsigned MAP_W      = 320,
    parameter int unsigned MAP_H      = 240,
    parameter int unsigned ACTIVE_W   = 640,
    parameter int unsigned HUD_Y      = 360,
    parameter logic [11:0] SEP_COLOR  = 12'hFFF,
    parameter logic [11:0] HUD_COLOR  = 12'h444,
    parameter logic [11:0] OOB_COLOR  = 12'h6B4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pix_en,
    input  logic [9:0]                h_cnt,
    input  logic [9:0]                v_cnt,
    input  logic                      valid_in,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic [10*NUM_VIEWS-1:0]   pos_x,
    input  logic [10*NUM_VIEWS-1:0]   pos_y,
    output logic [16:0]               map_addr,
    input  logic [3:0]                map_index,
    input  logic [11:0]               sprite_rgb,
    input  logic                      sprite_opaque,
    input  logic                      pal_we,
    input  logic [3:0]                pal_idx,
    input  logic [11:0]               pal_data,
    output logic [1:0]                view_id,
    output logic [9:0]                view_x,
    output logic                      frame_start,
    output logic [11:0]               rgb,
    output logic                      hsync,
    output logic                      vsync
);

    localparam int unsigned VIEW_W  = ACTIVE_W / NUM_VIEWS;
    localparam int unsigned VIEW_WW = VIEW_W >> ZOOM_SHIFT;   // viewport width in world px
    localparam int unsigned HUD_WH  = HUD_Y >> ZOOM_SHIFT;    // map window height in world px

    localparam logic signed [10:0] CAM_OFF_X = 11'(VIEW_WW >> 1);
    localparam logic signed [10:0] CAM_OFF_Y = 11'(HUD_WH >> 1);
    localparam logic signed [11:0] MAP_W_S   = 12'(MAP_W);
    localparam logic signed [11:0] MAP_H_S   = 12'(MAP_H);
    localparam logic [1:0]         LAST_VIEW = 2'(NUM_VIEWS - 1);

`ifdef CAMERA_CLAMP_EN
    localparam int unsigned        CLAMP_X_HI   = (MAP_W > VIEW_WW) ? MAP_W - VIEW_WW : 0;
    localparam int unsigned        CLAMP_Y_HI   = (MAP_H > HUD_WH) ? MAP_H - HUD_WH : 0;
    localparam logic signed [10:0] CLAMP_X_HI_S = 11'(CLAMP_X_HI);
    localparam logic signed [10:0] CLAMP_Y_HI_S = 11'(CLAMP_Y_HI);

    // Keep a camera inside [0, hi].
    function automatic logic signed [10:0] clamp_cam(input logic signed [10:0] v,
                                                     input logic signed [10:0] hi);
        if (v < 11'sd0) return 11'sd0;
        if (v > hi)     return hi;
        return v;
    endfunction
`endif

    // ---------------- camera latch ----------------
    logic signed [10:0] cam_x  [NUM_VIEWS];
    logic signed [10:0] cam_y  [NUM_VIEWS];
    logic signed [10:0] cam_nx [NUM_VIEWS];
    logic signed [10:0] cam_ny [NUM_VIEWS];
    logic               latch;

    assign latch = pix_en && (v_cnt == 10'd480) && (h_cnt == 10'd0);

    // Centre each camera on its player.
    always_comb begin
        for (int i = 0; i < int'(NUM_VIEWS); i++) begin
            cam_nx[i] = $signed({1'b0, pos_x[10*i +: 10]}) - CAM_OFF_X;
            cam_ny[i] = $signed({1'b0, pos_y[10*i +: 10]}) - CAM_OFF_Y;
`ifdef CAMERA_CLAMP_EN
            cam_nx[i] = clamp_cam(cam_nx[i], CLAMP_X_HI_S);
            cam_ny[i] = clamp_cam(cam_ny[i], CLAMP_Y_HI_S);
`endif
        end
    end

    // Cameras update only during vertical blanking, so a frame never tears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start <= 1'b0;
            for (int i = 0; i < int'(NUM_VIEWS); i++) begin
                cam_x[i] <= 11'sd0;
                cam_y[i] <= 11'sd0;
            end
        end else begin
            frame_start <= latch;
            if (latch) begin
                for (int i = 0; i < int'(NUM_VIEWS); i++) begin
                    cam_x[i] <= cam_nx[i];
                    cam_y[i] <= cam_ny[i];
                end
            end
        end
    end

    // ---------------- palette ----------------
    logic [11:0] pal [16];

    // Reads see the pre-write value when a write hits the same index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) pal[i] <= {4'(i), 4'(i), 4'(i)};
        end else if (pal_we) begin
            pal[pal_idx] <= pal_data;
        end
    end

    // ---------------- stage 0: geometry ----------------
    logic [1:0]         vid_c;
    logic [9:0]         vbase_c;
    logic [9:0]         vx_c;
    logic signed [10:0] csel_x_c;
    logic signed [10:0] csel_y_c;
    logic signed [11:0] wx_c;
    logic signed [11:0] wy_c;
    logic               oob_c;
    logic [16:0]        addr_c;
    logic               vsep_c;
    logic               hud_sep_c;
    logic               hud_band_c;

    // Compare chain picks the viewport and its camera without a divider.
    always_comb begin
        vid_c    = 2'd0;
        vbase_c  = 10'd0;
        csel_x_c = cam_x[0];
        csel_y_c = cam_y[0];
        for (int i = 1; i < int'(NUM_VIEWS); i++) begin
            if (h_cnt >= 10'(i * int'(VIEW_W))) begin
                vid_c    = 2'(i);
                vbase_c  = 10'(i * int'(VIEW_W));
                csel_x_c = cam_x[i];
                csel_y_c = cam_y[i];
            end
        end
        vx_c = h_cnt - vbase_c;

        wx_c   = 12'(csel_x_c) + $signed({2'b00, vx_c >> ZOOM_SHIFT});
        wy_c   = 12'(csel_y_c) + $signed({2'b00, v_cnt >> ZOOM_SHIFT});
        oob_c  = (wx_c < 12'sd0) || (wy_c < 12'sd0) || (wx_c >= MAP_W_S) || (wy_c >= MAP_H_S);
        // Operands are non-negative whenever the address is used.
        addr_c = oob_c ? 17'd0 : 17'(wy_c) * 17'(MAP_W) + 17'(wx_c);

        vsep_c = ((vx_c == 10'd0) && (vid_c != 2'd0)) ||
                 ((vx_c == 10'(VIEW_W - 1)) && (vid_c != LAST_VIEW));
        hud_sep_c  = (v_cnt == 10'(HUD_Y - 1)) || (v_cnt == 10'(HUD_Y));
        hud_band_c = v_cnt > 10'(HUD_Y);
    end

    // ---------------- stage 1 ----------------
    logic s1_oob, s1_valid, s1_hs, s1_vs, s1_vsep, s1_hud_sep, s1_hud_band;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            map_addr    <= 17'd0;
            view_id     <= 2'd0;
            view_x      <= 10'd0;
            s1_oob      <= 1'b0;
            s1_valid    <= 1'b0;
            s1_hs       <= 1'b1;
            s1_vs       <= 1'b1;
            s1_vsep     <= 1'b0;
            s1_hud_sep  <= 1'b0;
            s1_hud_band <= 1'b0;
        end else if (pix_en) begin
            map_addr    <= addr_c;
            view_id     <= vid_c;
            view_x      <= vx_c;
            s1_oob      <= oob_c;
            s1_valid    <= valid_in;
            s1_hs       <= hsync_in;
            s1_vs       <= vsync_in;
            s1_vsep     <= vsep_c;
            s1_hud_sep  <= hud_sep_c;
            s1_hud_band <= hud_band_c;
        end
    end

    // ---------------- stage 2: palette lookup, sprite sample ----------------
    logic [11:0] s2_pal, s2_spr_rgb;
    logic        s2_spr_op, s2_oob, s2_valid, s2_hs, s2_vs, s2_vsep, s2_hud_sep, s2_hud_band;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_pal      <= 12'd0;
            s2_spr_rgb  <= 12'd0;
            s2_spr_op   <= 1'b0;
            s2_oob      <= 1'b0;
            s2_valid    <= 1'b0;
            s2_hs       <= 1'b1;
            s2_vs       <= 1'b1;
            s2_vsep     <= 1'b0;
            s2_hud_sep  <= 1'b0;
            s2_hud_band <= 1'b0;
        end else if (pix_en) begin
            s2_pal      <= pal[map_index];
            s2_spr_rgb  <= sprite_rgb;
            s2_spr_op   <= sprite_opaque;
            s2_oob      <= s1_oob;
            s2_valid    <= s1_valid;
            s2_hs       <= s1_hs;
            s2_vs       <= s1_vs;
            s2_vsep     <= s1_vsep;
            s2_hud_sep  <= s1_hud_sep;
            s2_hud_band <= s1_hud_band;
        end
    end

    // ---------------- stage 3: compositing ----------------
    logic [11:0] color_c;

    always_comb begin
        color_c = s2_pal;
        if (!s2_valid)        color_c = 12'd0;
        else if (s2_hud_sep)  color_c = SEP_COLOR;
        else if (s2_hud_band) color_c = HUD_COLOR;
        else if (s2_vsep)     color_c = SEP_COLOR;
        else if (s2_spr_op)   color_c = s2_spr_rgb;
        else if (s2_oob)      color_c = OOB_COLOR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb   <= 12'd0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (pix_en) begin
            rgb   <= color_c;
            hsync <= s2_hs;
            vsync <= s2_vs;
        end
    end

endmodule

// File: tb/tb_split_view_compositor.sv
// Directed bench for split_view_compositor: a 2-view instance covers addressing,
// camera latching, palette, compositing priority, sync delay and reset. A 4-view
// instance covers viewport geometry and separators.
module tb_split_view_compositor;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic [9:0]  h_cnt, v_cnt;
    logic        valid_in, hsync_in, vsync_in;
    logic [19:0] pos_x, pos_y;
    logic [39:0] pos4_x, pos4_y;
    logic [3:0]  map_index;
    logic [11:0] sprite_rgb;
    logic        sprite_opaque;
    logic        pal_we;
    logic [3:0]  pal_idx;
    logic [11:0] pal_data;

    logic [16:0] map_addr, u4_map_addr;
    logic [1:0]  view_id, u4_view_id;
    logic [9:0]  view_x, u4_view_x;
    logic        frame_start, u4_frame_start;
    logic [11:0] rgb, u4_rgb;
    logic        hsync, vsync, u4_hsync, u4_vsync;

    int n_cmp = 0;
    int n_err = 0;

    logic [16:0] a;
    logic [11:0] c;
    logic [1:0]  vid;
    logic [9:0]  vx;

    always #5 clk = ~clk;

    split_view_compositor dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .valid_in(valid_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pos_x(pos_x), .pos_y(pos_y), .map_addr(map_addr), .map_index(map_index),
        .sprite_rgb(sprite_rgb), .sprite_opaque(sprite_opaque),
        .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
        .view_id(view_id), .view_x(view_x), .frame_start(frame_start),
        .rgb(rgb), .hsync(hsync), .vsync(vsync)
    );

    split_view_compositor #(.NUM_VIEWS(4)) u4 (
        .clk(clk), .rst(rst), .pix_en(pix_en), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .valid_in(valid_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pos_x(pos4_x), .pos_y(pos4_y), .map_addr(u4_map_addr), .map_index(map_index),
        .sprite_rgb(sprite_rgb), .sprite_opaque(sprite_opaque),
        .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
        .view_id(u4_view_id), .view_x(u4_view_x), .frame_start(u4_frame_start),
        .rgb(u4_rgb), .hsync(u4_hsync), .vsync(u4_vsync)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One pixel strobe; returns at the falling edge right after the strobe edge.
    task automatic step();
        @(negedge clk) pix_en = 1'b1;
        @(negedge clk) pix_en = 1'b0;
    endtask

    task automatic set_pix(input int h, input int v, input logic vld);
        h_cnt    = 10'(h);
        v_cnt    = 10'(v);
        valid_in = vld;
    endtask

    task automatic latch_cams();
        set_pix(0, 480, 1'b0);
        step();
        check("frame_start_pulse", 32'(frame_start), 32'd1);
        @(negedge clk);
        check("frame_start_drop", 32'(frame_start), 32'd0);
    endtask

    // Drive one pixel; map data and sprite follow one strobe later.
    task automatic run_pix(input int h, input int v, input logic [3:0] idx,
                           input logic op, input logic [11:0] srgb,
                           output logic [16:0] addr, output logic [11:0] color,
                           output logic [1:0] vid_o, output logic [9:0] vx_o);
        set_pix(h, v, 1'b1);
        step();
        addr  = map_addr;
        vid_o = view_id;
        vx_o  = view_x;
        map_index     = idx;
        sprite_opaque = op;
        sprite_rgb    = srgb;
        step();
        step();
        color = rgb;
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b0;
        h_cnt = '0; v_cnt = '0; valid_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        pos_x = {10'd200, 10'd100}; pos_y = {10'd50, 10'd100};
        pos4_x = '0; pos4_y = '0;
        map_index = '0; sprite_rgb = '0; sprite_opaque = 1'b0;
        pal_we = 1'b0; pal_idx = '0; pal_data = '0;
        repeat (3) @(negedge clk);

        check("rst_rgb", 32'(rgb), 32'h0);
        check("rst_hsync", 32'(hsync), 32'd1);
        check("rst_vsync", 32'(vsync), 32'd1);
        check("rst_map_addr", 32'(map_addr), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        rst = 1'b0;

        // cam0 = (60,55), cam1 = (160,5)
        latch_cams();
        run_pix(0, 0, 4'd7, 1'b0, 12'h000, a, c, vid, vx);
        check("p00_addr", 32'(a), 32'd17660);
        check("p00_rgb_reset_pal", 32'(c), 32'h777);
        run_pix(320, 20, 4'd0, 1'b0, 12'h000, a, c, vid, vx);
        check("p320_addr", 32'(a), 32'd3360);
        check("p320_view_id", 32'(vid), 32'd1);
        check("p320_view_x", 32'(vx), 32'd0);
        check("p320_rgb_sep", 32'(c), 32'hFFF);

        // Mid-frame position change must not move the camera
        pos_x = {10'd200, 10'd500};
        run_pix(0, 0, 4'd7, 1'b0, 12'h000, a, c, vid, vx);
        check("midframe_addr", 32'(a), 32'd17660);
        check("midframe_no_pulse", 32'(frame_start), 32'd0);

        @(negedge clk) begin pal_we = 1'b1; pal_idx = 4'd3; pal_data = 12'hF00; end
        @(negedge clk) pal_we = 1'b0;

        run_pix(10, 10, 4'd3, 1'b0, 12'h000, a, c, vid, vx);
        check("p10_addr", 32'(a), 32'd18302);
        check("p10_rgb_pal", 32'(c), 32'hF00);
        run_pix(10, 10, 4'd3, 1'b1, 12'h0F0, a, c, vid, vx);
        check("p10_rgb_sprite", 32'(c), 32'h0F0);
        run_pix(319, 10, 4'd3, 1'b1, 12'h0F0, a, c, vid, vx);
        check("p319_view_x", 32'(vx), 32'd319);
        check("p319_rgb_sep", 32'(c), 32'hFFF);
        run_pix(10, 359, 4'd3, 1'b1, 12'h0F0, a, c, vid, vx);
        check("v359_sep", 32'(c), 32'hFFF);
        run_pix(10, 360, 4'd3, 1'b0, 12'h000, a, c, vid, vx);
        check("v360_sep", 32'(c), 32'hFFF);
        run_pix(10, 361, 4'd3, 1'b0, 12'h000, a, c, vid, vx);
        check("v361_hud", 32'(c), 32'h444);
        run_pix(10, 400, 4'd3, 1'b1, 12'h0F0, a, c, vid, vx);
        check("v400_hud", 32'(c), 32'h444);

        // Blanked pixel
        sprite_opaque = 1'b0;
        set_pix(10, 10, 1'b0);
        repeat (3) step();
        check("invalid_black", 32'(rgb), 32'h0);

        // Sync delay is exactly three strobes
        set_pix(10, 10, 1'b1);
        hsync_in = 1'b0; vsync_in = 1'b0;
        step(); step();
        check("hsync_lag2", 32'(hsync), 32'd1);
        check("vsync_lag2", 32'(vsync), 32'd1);
        step();
        check("hsync_lag3", 32'(hsync), 32'd0);
        check("vsync_lag3", 32'(vsync), 32'd0);
        hsync_in = 1'b1; vsync_in = 1'b1;
        repeat (3) step();
        check("hsync_back", 32'(hsync), 32'd1);

        // Four views: boundaries at 160/320/480
        set_pix(479, 10, 1'b1);
        step();
        check("u4_479_view_id", 32'(u4_view_id), 32'd2);
        check("u4_479_view_x", 32'(u4_view_x), 32'd159);
        step(); step();
        check("u4_479_sep", 32'(u4_rgb), 32'hFFF);
        set_pix(480, 10, 1'b1);
        step();
        check("u4_480_view_id", 32'(u4_view_id), 32'd3);
        check("u4_480_view_x", 32'(u4_view_x), 32'd0);
        step(); step();
        check("u4_480_sep", 32'(u4_rgb), 32'hFFF);

        // New latch: view0 player at (500,100)
        latch_cams();
        run_pix(0, 0, 4'd7, 1'b0, 12'h000, a, c, vid, vx);
`ifdef CAMERA_CLAMP_EN
        check("far_addr", 32'(a), 32'd17840);
        check("far_rgb", 32'(c), 32'h777);
`else
        check("far_addr", 32'(a), 32'd0);
        check("far_rgb_oob", 32'(c), 32'h6B4);
`endif

        // View0 player near the corner at (5,5)
        pos_x = {10'd200, 10'd5}; pos_y = {10'd50, 10'd5};
        latch_cams();
        run_pix(0, 0, 4'd7, 1'b0, 12'h000, a, c, vid, vx);
        check("corner_addr", 32'(a), 32'd0);
`ifdef CAMERA_CLAMP_EN
        check("corner_rgb", 32'(c), 32'h777);
`else
        check("corner_rgb_oob", 32'(c), 32'h6B4);
`endif

        // Asynchronous reset mid-line
        set_pix(10, 10, 1'b1);
        map_index = 4'd3;
        hsync_in = 1'b0; vsync_in = 1'b0;
        repeat (3) step();
        check("pre_rst_hsync", 32'(hsync), 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_rgb", 32'(rgb), 32'h0);
        check("async_rst_hsync", 32'(hsync), 32'd1);
        check("async_rst_vsync", 32'(vsync), 32'd1);
        @(negedge clk) rst = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1;
        // Cameras back at 0, palette back to {i,i,i}
        set_pix(10, 10, 1'b1);
        step();
        check("post_rst_addr", 32'(map_addr), 32'd642);
        step();
        check("post_rst_black", 32'(rgb), 32'h0);
        step();
        check("post_rst_rgb", 32'(rgb), 32'h333);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
